vertex_transform: RTL and testbench

// Consumes the combined Q8.8 mvp matrix from the draw stage and maps one object-space vertex at a time to screen space.

---
 rtl/vertex_transform.sv | 241 ++++++++++++++++++++++++
 tb/tb_vertex_transform.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vertex_transform.sv
// vertex_transform: maps one Q8.8 object-space vertex through a latched 4x4 mvp matrix,
// then applies the perspective divide and viewport mapping, with valid/ready on both sides.
module vertex_transform #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned COORD_W  = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [15:0][15:0]   mvp_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [15:0]         vx_i,
  input  logic [15:0]         vy_i,
  input  logic [15:0]         vz_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [COORD_W-1:0]  screen_x_o,
  output logic [COORD_W-1:0]  screen_y_o,
  output logic [15:0]         depth_o,
  output logic                out_clip_o
);

  localparam int XMax = int'(SCREEN_W) - 1;
  localparam int YMax = int'(SCREEN_H) - 1;

  typedef enum logic [2:0] {StIdle, StMac, StWchk, StDiv, StMap, StOut} state_e;

  state_e                state_q, state_d;
  logic [15:0][15:0]     mvp_q, mvp_d;
  logic signed [15:0]    vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
  logic signed [35:0]    acc_q, acc_d;
  logic [3:0][15:0]      clip_q, clip_d;
  logic [2:0][15:0]      ndc_q, ndc_d;
  logic [23:0]           dq_q, dq_d;
  logic [15:0]           rem_q, rem_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [1:0]            comp_q, comp_d;
  logic [COORD_W-1:0]    sx_q, sx_d, sy_q, sy_d;
  logic [15:0]           depth_q, depth_d;
  logic                  oclip_q, oclip_d;

  function automatic logic [16:0] abs17(input logic [15:0] a);
    logic signed [16:0] s;
    s = {a[15], a};
    return s[16] ? 17'(-s) : 17'(s);
  endfunction

  // MAC datapath: cycle index k selects matrix word 4r+c and vector element c
  logic [3:0]          mac_idx;
  logic signed [15:0]  mac_coef, mac_vec;
  logic signed [31:0]  mac_prod;
  logic signed [35:0]  mac_base, mac_sum;
  logic signed [27:0]  mac_shr;
  logic [15:0]         mac_sat;

  always_comb begin
    mac_idx  = cnt_q[3:0];
    mac_coef = $signed(mvp_q[mac_idx]);
    unique case (mac_idx[1:0])
      2'd0:    mac_vec = vx_q;
      2'd1:    mac_vec = vy_q;
      2'd2:    mac_vec = vz_q;
      default: mac_vec = 16'sh0100;
    endcase
    mac_prod = mac_coef * mac_vec;
    mac_base = (mac_idx[1:0] == 2'd0) ? 36'sd0 : acc_q;
    mac_sum  = mac_base + $signed({{4{mac_prod[31]}}, mac_prod});
    mac_shr  = $signed(mac_sum[35:8]);
    if (mac_shr > 28'sd32767)       mac_sat = 16'h7FFF;
    else if (mac_shr < -28'sd32768) mac_sat = 16'h8000;
    else                            mac_sat = mac_shr[15:0];
  end

  // Restoring divider, one quotient bit per cycle; dividend loaded on the first bit
  logic [15:0] div_clip, div_mag, div_rem_in, div_rem_nxt, div_qsat, div_res;
  logic [23:0] div_src, div_q_nxt;
  logic [16:0] div_trial, div_diff;
  logic        div_ge;

  always_comb begin
    div_clip    = clip_q[comp_q];
    div_mag     = div_clip[15] ? (16'd0 - div_clip) : div_clip;
    div_src     = (cnt_q == 5'd0) ? {div_mag, 8'h00} : dq_q;
    div_rem_in  = (cnt_q == 5'd0) ? 16'd0 : rem_q;
    div_trial   = {div_rem_in, div_src[23]};
    div_diff    = div_trial - {1'b0, clip_q[3]};
    div_ge      = ~div_diff[16];
    div_rem_nxt = div_ge ? div_diff[15:0] : div_trial[15:0];
    div_q_nxt   = {div_src[22:0], div_ge};
    div_qsat    = (div_q_nxt[23:15] != 9'd0) ? 16'h7FFF : div_q_nxt[15:0];
    div_res     = div_clip[15] ? (16'd0 - div_qsat) : div_qsat;
  end

  // Viewport mapping from NDC to pixel coordinates, row 0 at the top
  logic signed [31:0]   ndc_x_ext, ndc_y_ext, map_x, map_y;
  logic [COORD_W-1:0]   map_sx, map_sy;
  logic                 map_clip;

  always_comb begin
    ndc_x_ext = $signed({{16{ndc_q[0][15]}}, ndc_q[0]});
    ndc_y_ext = $signed({{16{ndc_q[1][15]}}, ndc_q[1]});
    map_x = ((ndc_x_ext + 32'sd256) * $signed(SCREEN_W)) >>> 9;
    map_y = ((32'sd256 - ndc_y_ext) * $signed(SCREEN_H)) >>> 9;
    if (map_x < 0)         map_sx = '0;
    else if (map_x > XMax) map_sx = COORD_W'(XMax);
    else                   map_sx = map_x[COORD_W-1:0];
    if (map_y < 0)         map_sy = '0;
    else if (map_y > YMax) map_sy = COORD_W'(YMax);
    else                   map_sy = map_y[COORD_W-1:0];
    map_clip = (abs17(ndc_q[0]) > 17'd256) || (abs17(ndc_q[1]) > 17'd256) ||
               (abs17(ndc_q[2]) > 17'd256);
  end

  always_comb begin
    state_d = state_q;
    mvp_d   = mvp_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vz_d    = vz_q;
    acc_d   = acc_q;
    clip_d  = clip_q;
    ndc_d   = ndc_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    comp_d  = comp_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    depth_d = depth_q;
    oclip_d = oclip_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          mvp_d   = mvp_i;
          vx_d    = vx_i;
          vy_d    = vy_i;
          vz_d    = vz_i;
          cnt_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = mac_sum;
        cnt_d = cnt_q + 5'd1;
        if (mac_idx[1:0] == 2'd3) clip_d[mac_idx[3:2]] = mac_sat;
        if (mac_idx == 4'd15) begin
          cnt_d   = '0;
          state_d = StWchk;
        end
      end
      StWchk: begin
        if ($signed(clip_q[3]) <= 16'sd0) begin
          sx_d    = '0;
          sy_d    = '0;
          depth_d = '0;
          oclip_d = 1'b1;
          state_d = StOut;
        end else begin
          cnt_d   = '0;
          comp_d  = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        dq_d  = div_q_nxt;
        rem_d = div_rem_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          cnt_d  = '0;
          comp_d = comp_q + 2'd1;
          unique case (comp_q)
            2'd0:    ndc_d[0] = div_res;
            2'd1:    ndc_d[1] = div_res;
            default: begin
              ndc_d[2] = div_res;
              state_d  = StMap;
            end
          endcase
        end
      end
      StMap: begin
        sx_d    = map_sx;
        sy_d    = map_sy;
        depth_d = ndc_q[2];
        oclip_d = map_clip;
        state_d = StOut;
      end
      StOut: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mvp_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vz_q    <= '0;
      acc_q   <= '0;
      clip_q  <= '0;
      ndc_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      comp_q  <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      depth_q <= '0;
      oclip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mvp_q   <= mvp_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vz_q    <= vz_d;
      acc_q   <= acc_d;
      clip_q  <= clip_d;
      ndc_q   <= ndc_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      comp_q  <= comp_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      depth_q <= depth_d;
      oclip_q <= oclip_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StOut);
  assign screen_x_o  = sx_q;
  assign screen_y_o  = sy_q;
  assign depth_o     = depth_q;
  assign out_clip_o  = oclip_q;

endmodule

// File: tb/tb_vertex_transform.sv
// Bench for vertex_transform: directed and random vertices checked against an integer model
// of the transform, latency, output hold under backpressure and reset abort.
module tb_vertex_transform;

  localparam int SW = 640;
  localparam int SH = 480;
  localparam int CW = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0][15:0] mvp;
  logic              in_valid, in_ready, out_valid, out_ready, out_clip;
  logic [15:0]       vx, vy, vz, depth;
  logic [CW-1:0]     sx, sy;
  int                n_cmp = 0;
  int                n_bad = 0;

  always #5 clk = ~clk;

  vertex_transform #(
    .SCREEN_W(SW),
    .SCREEN_H(SH),
    .COORD_W (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mvp_i      (mvp),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .vx_i       (vx),
    .vy_i       (vy),
    .vz_i       (vz),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .screen_x_o (sx),
    .screen_y_o (sy),
    .depth_o    (depth),
    .out_clip_o (out_clip)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the transform definition
  function automatic void model(input logic [15:0][15:0] m, input logic [15:0] x,
                                input logic [15:0] y, input logic [15:0] z,
                                output int e_sx, output int e_sy, output int e_dep,
                                output int e_clip, output int e_lat);
    longint acc;
    int     cc[4];
    int     v[4];
    int     nd[3];
    int     w, mag, q;
    v[0] = int'($signed(x));
    v[1] = int'($signed(y));
    v[2] = int'($signed(z));
    v[3] = 256;
    for (int r = 0; r < 4; r++) begin
      acc = 0;
      for (int c = 0; c < 4; c++) acc += longint'(int'($signed(m[4*r+c]))) * longint'(v[c]);
      acc = acc >>> 8;
      cc[r] = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : int'(acc);
    end
    w = cc[3];
    if (w <= 0) begin
      e_sx = 0; e_sy = 0; e_dep = 0; e_clip = 1; e_lat = 17;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      mag = (cc[i] < 0) ? -cc[i] : cc[i];
      q = (mag * 256) / w;
      if (q > 32767) q = 32767;
      nd[i] = (cc[i] < 0) ? -q : q;
    end
    e_sx = ((nd[0] + 256) * SW) >>> 9;
    e_sy = ((256 - nd[1]) * SH) >>> 9;
    if (e_sx < 0) e_sx = 0;
    if (e_sx > SW - 1) e_sx = SW - 1;
    if (e_sy < 0) e_sy = 0;
    if (e_sy > SH - 1) e_sy = SH - 1;
    e_dep  = nd[2] & 'hFFFF;
    e_clip = (nd[0] > 256 || nd[0] < -256 || nd[1] > 256 || nd[1] < -256 ||
              nd[2] > 256 || nd[2] < -256) ? 1 : 0;
    e_lat  = 90;
  endfunction

  function automatic logic [15:0] rnd_s(input int lo, input int hi);
    int t;
    t = lo + int'($urandom_range(0, hi - lo));
    return t[15:0];
  endfunction

  task automatic run_vertex(input string tag, input logic [15:0][15:0] m, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] z, input int hold);
    int            e_sx, e_sy, e_dep, e_clip, e_lat, lat;
    logic [CW-1:0] s_sx, s_sy;
    logic [15:0]   s_dep;
    logic          s_clip;
    model(m, x, y, z, e_sx, e_sy, e_dep, e_clip, e_lat);
    mvp = m; vx = x; vy = y; vz = z; in_valid = 1'b1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; the block must use its latched copy
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) mvp[i] = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      vx = 16'($urandom); vy = 16'($urandom); vz = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'(e_lat));
    check({tag, ".screen_x"}, 64'(sx), 64'(e_sx));
    check({tag, ".screen_y"}, 64'(sy), 64'(e_sy));
    check({tag, ".depth"}, 64'(depth), 64'(e_dep));
    check({tag, ".out_clip"}, 64'(out_clip), 64'(e_clip));
    s_sx = sx; s_sy = sy; s_dep = depth; s_clip = out_clip;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold"}, 64'({out_valid, in_ready, out_clip, depth, sy, sx}),
            64'({1'b1, 1'b0, s_clip, s_dep, s_sy, s_sx}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".release"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][15:0] ident, m;
    bit                seen_valid;
    for (int i = 0; i < 16; i++) ident[i] = (i % 5 == 0) ? 16'h0100 : 16'h0000;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mvp = '0; vx = '0; vy = '0; vz = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 64'({out_valid, in_ready, out_clip, depth, sy, sx}),
          64'({1'b0, 1'b1, 1'b0, 16'h0, {CW{1'b0}}, {CW{1'b0}}}));
    rst = 1'b0;
    @(posedge clk); #1;

    run_vertex("ident_x1", ident, 16'h0100, 16'h0080, 16'h0000, 0);
    run_vertex("ident_zero", ident, 16'h0000, 16'h0000, 16'h0000, 5);
    m = ident;
    m[12] = 16'h0000; m[13] = 16'h0000; m[14] = 16'h0100; m[15] = 16'h0000;
    run_vertex("persp", m, 16'h0100, 16'h0100, 16'h0200, 1);
    run_vertex("w_neg", m, 16'h0000, 16'h0000, 16'hFF00, 5);
    m = ident;
    m[0] = 16'h7FFF;
    run_vertex("sat", m, 16'h7FFF, 16'h0000, 16'h0000, 2);

    // Reset while dividing: state must be cleared and the aborted vertex never emerge
    mvp = ident; vx = 16'h0100; vy = 16'h0080; vz = 16'h0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_div", 64'({out_valid, in_ready, out_clip, depth, sy, sx}),
          64'({1'b0, 1'b1, 1'b0, 16'h0, {CW{1'b0}}, {CW{1'b0}}}));
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("rst_no_result", 64'(seen_valid), 64'(0));
    run_vertex("after_rst", ident, 16'hFF80, 16'h0040, 16'h0020, 0);

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 16; i++) m[i] = (n % 6 == 5) ? 16'($urandom) : rnd_s(-512, 512);
      if (n % 6 != 5) begin
        m[12] = rnd_s(-64, 64); m[13] = rnd_s(-64, 64);
        m[14] = rnd_s(-64, 64); m[15] = rnd_s(-64, 448);
      end
      run_vertex("rand", m, rnd_s(-1024, 1024), rnd_s(-1024, 1024), rnd_s(-1024, 1024),
                 int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
